// File: rtl/mmv_pkg.sv
// Shared helpers for the MMV output packer: lane width, counter widths, bank id.
package mmv_pkg;

    // One bit is enough to name one of the two ping-pong banks.
    typedef logic bank_id_t;

    // Width of one lane: one channel group of one pixel.
    function automatic int lane_width(input int pe, input int prec);
        return pe * prec;
    endfunction

    // Counter width that can hold max_val itself; never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val <= 1) ? 1 : $clog2(max_val) + 1;
    endfunction

    // Address width for a memory of the given depth; never less than one bit.
    function automatic int addr_width(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/mmv_output_packer_if.sv
// Valid/ready stream bundle used on both sides of the MMV output packer.
interface mmv_output_packer_if #(
    parameter int W = 8
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/mmv_lane_bank_ram.sv
// One lane of the ping-pong store: two banks of DEPTH words, registered read.
module mmv_lane_bank_ram
    import mmv_pkg::*;
#(
    parameter int    W         = 8,
    parameter int    DEPTH     = 2,
    parameter string RAM_STYLE = "auto",
    parameter int    AW        = addr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  bank_id_t      wr_bank,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  bank_id_t      rd_bank,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    (* ram_style = RAM_STYLE *) logic [W-1:0] mem [2][DEPTH];

    // Write port: one channel-group word into the bank being filled.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][wr_addr] <= wr_data;
        end
    end

    // Read port: output register doubles as the pipeline's r stage, so it only moves on rd_en.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_bank][rd_addr];
        end
    end

endmodule

// File: rtl/mmv_output_packer.sv
// Gathers a per-pixel channel-group stream into MMV-pixel-wide words using two
// ping-pong banks; lanes past the end of a row are zero-filled.
module mmv_output_packer
    import mmv_pkg::*;
#(
    parameter int    PE           = 1,
    parameter int    OFMChannels  = 2,
    parameter int    OFMWidth     = 6,
    parameter int    OFMHeight    = 6,
    parameter int    OP_PRECISION = 8,
    parameter int    MMV          = 2,
    parameter string RAM_STYLE    = "auto"
) (
    input  logic                 clk,
    input  logic                 resetn,
    mmv_output_packer_if.slave   ip_axis,
    mmv_output_packer_if.master  op_axis
);

    localparam int EFF_CH = OFMChannels / PE;
    localparam int W      = lane_width(PE, OP_PRECISION);
    localparam int CHW    = cnt_width(EFF_CH);
    localparam int LNW    = cnt_width(MMV);
    localparam int COLW   = cnt_width(OFMWidth);
    localparam int ROWW   = cnt_width(OFMHeight);
    localparam int AW     = addr_width(EFF_CH);

    localparam logic [CHW-1:0]  CH_LAST   = CHW'(EFF_CH - 1);
    localparam logic [LNW-1:0]  LANE_LAST = LNW'(MMV - 1);
    localparam logic [COLW-1:0] COL_LAST  = COLW'(OFMWidth - 1);
    localparam logic [ROWW-1:0] ROW_LAST  = ROWW'(OFMHeight - 1);

    logic [CHW-1:0]   ch_reg;
    logic [LNW-1:0]   lane_reg;
    logic [COLW-1:0]  col_reg;
    logic [ROWW-1:0]  row_reg;
    bank_id_t         wb_reg;
    bank_id_t         rb_reg;
    logic [1:0]       full_reg;
    logic [LNW-1:0]   nlanes_reg [2];
    logic [CHW-1:0]   rd_ch_reg;
    logic             r_valid_reg;
    logic [LNW-1:0]   r_nlanes_reg;
    logic             q_valid_reg;
    logic [MMV*W-1:0] q_data_reg;

    logic             accept;
    logic             ch_last;
    logic             close_bank;
    logic             advance;
    logic             issue;
    logic             issue_last;
    logic [W-1:0]     lane_rd [MMV];
    logic [MMV*W-1:0] packed_word;

    // Ready depends only on local state (and reset), never on the downstream ready.
    assign ip_axis.tready = resetn & ~full_reg[wb_reg];
    assign accept         = ip_axis.tvalid & ip_axis.tready;
    assign ch_last        = (ch_reg == CH_LAST);
    assign close_bank     = accept & ch_last & ((lane_reg == LANE_LAST) | (col_reg == COL_LAST));

    assign advance    = ~q_valid_reg | op_axis.tready;
    assign issue      = advance & full_reg[rb_reg];
    assign issue_last = issue & (rd_ch_reg == CH_LAST);

    assign op_axis.tvalid = q_valid_reg;
    assign op_axis.tdata  = q_data_reg;

    // Position counters: channel group fastest, then lane/column, then row; wrap at frame end.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ch_reg   <= '0;
            lane_reg <= '0;
            col_reg  <= '0;
            row_reg  <= '0;
        end else if (accept) begin
            if (ch_last) begin
                ch_reg   <= '0;
                lane_reg <= close_bank ? '0 : lane_reg + LNW'(1);
                if (col_reg == COL_LAST) begin
                    col_reg <= '0;
                    row_reg <= (row_reg == ROW_LAST) ? '0 : row_reg + ROWW'(1);
                end else begin
                    col_reg <= col_reg + COLW'(1);
                end
            end else begin
                ch_reg <= ch_reg + CHW'(1);
            end
        end
    end

    // Bank bookkeeping: a close fills the write bank, the last read frees the read bank;
    // both may happen in one cycle because they always target different banks.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            full_reg      <= '0;
            wb_reg        <= '0;
            rb_reg        <= '0;
            nlanes_reg[0] <= '0;
            nlanes_reg[1] <= '0;
            rd_ch_reg     <= '0;
        end else begin
            if (close_bank) begin
                full_reg[wb_reg]   <= 1'b1;
                nlanes_reg[wb_reg] <= lane_reg + LNW'(1);
                wb_reg             <= ~wb_reg;
            end
            if (issue) begin
                if (issue_last) begin
                    rd_ch_reg        <= '0;
                    full_reg[rb_reg] <= 1'b0;
                    rb_reg           <= ~rb_reg;
                end else begin
                    rd_ch_reg <= rd_ch_reg + CHW'(1);
                end
            end
        end
    end

    // r/q pipeline: r is the RAM output register, q the output register; both move together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid_reg  <= 1'b0;
            r_nlanes_reg <= '0;
            q_valid_reg  <= 1'b0;
            q_data_reg   <= '0;
        end else if (advance) begin
            r_valid_reg <= issue;
            if (issue) begin
                r_nlanes_reg <= nlanes_reg[rb_reg];
            end
            q_valid_reg <= r_valid_reg;
            q_data_reg  <= r_valid_reg ? packed_word : '0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < MMV; gi++) begin : g_lane
            mmv_lane_bank_ram #(
                .W         (W),
                .DEPTH     (EFF_CH),
                .RAM_STYLE (RAM_STYLE)
            ) u_ram (
                .clk     (clk),
                .wr_en   (accept && (lane_reg == LNW'(gi))),
                .wr_bank (wb_reg),
                .wr_addr (ch_reg[AW-1:0]),
                .wr_data (ip_axis.tdata),
                .rd_en   (issue),
                .rd_bank (rb_reg),
                .rd_addr (rd_ch_reg[AW-1:0]),
                .rd_data (lane_rd[gi])
            );

            // Lanes beyond the live count of a row-tail group read as zero.
            assign packed_word[gi*W +: W] = (LNW'(gi) < r_nlanes_reg) ? lane_rd[gi] : '0;
        end
    endgenerate

endmodule

// File: tb/tb_mmv_output_packer.sv
`timescale 1ns/1ps
module tb_mmv_output_packer;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // A: PE1 Ch2 W3 H1 MMV2 (row tail); B: PE2 Ch4 W5 H3 MMV3 (tail); C: PE1 Ch2 W4 H2 MMV2 (no tail)
    mmv_output_packer_if #(.W(8))  ip_a ();
    mmv_output_packer_if #(.W(16)) op_a ();
    mmv_output_packer_if #(.W(16)) ip_b ();
    mmv_output_packer_if #(.W(48)) op_b ();
    mmv_output_packer_if #(.W(8))  ip_c ();
    mmv_output_packer_if #(.W(16)) op_c ();

    mmv_output_packer #(.PE(1), .OFMChannels(2), .OFMWidth(3), .OFMHeight(1),
                        .OP_PRECISION(8), .MMV(2), .RAM_STYLE("auto"))
        u_a (.clk(clk), .resetn(resetn), .ip_axis(ip_a), .op_axis(op_a));
    mmv_output_packer #(.PE(2), .OFMChannels(4), .OFMWidth(5), .OFMHeight(3),
                        .OP_PRECISION(8), .MMV(3), .RAM_STYLE("auto"))
        u_b (.clk(clk), .resetn(resetn), .ip_axis(ip_b), .op_axis(op_b));
    mmv_output_packer #(.PE(1), .OFMChannels(2), .OFMWidth(4), .OFMHeight(2),
                        .OP_PRECISION(8), .MMV(2), .RAM_STYLE("auto"))
        u_c (.clk(clk), .resetn(resetn), .ip_axis(ip_c), .op_axis(op_c));

    logic [63:0] in_q_a[$], in_q_b[$], in_q_c[$];
    logic [63:0] got_q_a[$], got_q_b[$], got_q_c[$];
    int          acc_cyc_a[$], acc_cyc_b[$], acc_cyc_c[$];
    int          got_cyc_a[$];
    int          vp_a = 0, vp_b = 0, vp_c = 0;
    int          rp_a = 0, rp_b = 0, rp_c = 0;
    logic        stall_a = 0, stall_b = 0, stall_c = 0;
    logic [63:0] held_a = 0, held_b = 0, held_c = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cmp_q(input string tag, input logic [63:0] got[$], input logic [63:0] exp[$]);
        check({tag, "_count"}, 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < got.size()) check($sformatf("%s_w%0d", tag, i), got[i], exp[i]);
        end
    endtask

    // Reference: lane m of word (group g, channel c) is pixel g+m, zero past the row end.
    task automatic model(input int pe, input int eff, input int w, input int h, input int mmv,
                         input int frames, input logic [63:0] beats[$], output logic [63:0] exp[$]);
        int lw;
        logic [63:0] word;
        lw = pe * 8;
        exp = {};
        for (int f = 0; f < frames; f++)
            for (int r = 0; r < h; r++)
                for (int g = 0; g < w; g += mmv)
                    for (int c = 0; c < eff; c++) begin
                        word = 0;
                        for (int m = 0; m < mmv; m++)
                            if (g + m < w) word |= beats[(((f * h + r) * w) + g + m) * eff + c] << (m * lw);
                        exp.push_back(word);
                    end
    endtask

    task automatic gen(input int n, input int lw, output logic [63:0] q[$]);
        logic [63:0] mask;
        mask = (64'h1 << lw) - 64'h1;
        q = {};
        repeat (n) q.push_back(({$urandom(), $urandom()} & mask) | 64'h1);
    endtask

    // Drivers: present at negedge, record acceptance just after (tready is registered-state only).
    initial begin
        ip_a.tvalid = 0; ip_a.tdata = 0;
        forever begin
            @(negedge clk);
            if (in_q_a.size() > 0 && int'($urandom_range(99)) < vp_a) begin
                ip_a.tvalid = 1; ip_a.tdata = in_q_a[0][7:0];
            end else ip_a.tvalid = 0;
            #1;
            if (ip_a.tvalid && ip_a.tready) begin void'(in_q_a.pop_front()); acc_cyc_a.push_back(cyc); end
        end
    end
    initial begin
        ip_b.tvalid = 0; ip_b.tdata = 0;
        forever begin
            @(negedge clk);
            if (in_q_b.size() > 0 && int'($urandom_range(99)) < vp_b) begin
                ip_b.tvalid = 1; ip_b.tdata = in_q_b[0][15:0];
            end else ip_b.tvalid = 0;
            #1;
            if (ip_b.tvalid && ip_b.tready) begin void'(in_q_b.pop_front()); acc_cyc_b.push_back(cyc); end
        end
    end
    initial begin
        ip_c.tvalid = 0; ip_c.tdata = 0;
        forever begin
            @(negedge clk);
            if (in_q_c.size() > 0 && int'($urandom_range(99)) < vp_c) begin
                ip_c.tvalid = 1; ip_c.tdata = in_q_c[0][7:0];
            end else ip_c.tvalid = 0;
            #1;
            if (ip_c.tvalid && ip_c.tready) begin void'(in_q_c.pop_front()); acc_cyc_c.push_back(cyc); end
        end
    end

    // Monitors: collect words, and check tdata holds across a stalled edge.
    initial begin
        op_a.tready = 0;
        forever begin
            @(negedge clk);
            if (stall_a && resetn) check("hold_a", 64'(op_a.tdata), held_a);
            op_a.tready = int'($urandom_range(99)) < rp_a;
            #1;
            if (op_a.tvalid && op_a.tready) begin got_q_a.push_back(64'(op_a.tdata)); got_cyc_a.push_back(cyc); end
            stall_a = resetn && op_a.tvalid && !op_a.tready;
            held_a  = 64'(op_a.tdata);
        end
    end
    initial begin
        op_b.tready = 0;
        forever begin
            @(negedge clk);
            if (stall_b && resetn) check("hold_b", 64'(op_b.tdata), held_b);
            op_b.tready = int'($urandom_range(99)) < rp_b;
            #1;
            if (op_b.tvalid && op_b.tready) got_q_b.push_back(64'(op_b.tdata));
            stall_b = resetn && op_b.tvalid && !op_b.tready;
            held_b  = 64'(op_b.tdata);
        end
    end
    initial begin
        op_c.tready = 0;
        forever begin
            @(negedge clk);
            if (stall_c && resetn) check("hold_c", 64'(op_c.tdata), held_c);
            op_c.tready = int'($urandom_range(99)) < rp_c;
            #1;
            if (op_c.tvalid && op_c.tready) got_q_c.push_back(64'(op_c.tdata));
            stall_c = resetn && op_c.tvalid && !op_c.tready;
            held_c  = 64'(op_c.tdata);
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] beats[$];
        logic [63:0] exp[$];
        logic [63:0] word;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        #2;
        check("rst_tvalid", 64'(op_a.tvalid), 64'd0);
        check("rst_tdata", 64'(op_a.tdata), 64'd0);
        check("rst_tready", 64'(ip_a.tready), 64'd0);
        @(negedge clk);
        resetn = 1;
        #2;
        check("tready_after_rst", 64'(ip_a.tready), 64'd1);

        // ---- 1: directed frame on A ----
        beats = '{64'h00, 64'h01, 64'h10, 64'h11, 64'h20, 64'h21};
        vp_a = 100; rp_a = 100;
        acc_cyc_a.delete(); got_q_a.delete(); got_cyc_a.delete();
        in_q_a = beats;
        for (int i = 0; i < 200 && got_q_a.size() < 4; i++) @(negedge clk);
        exp = '{64'h1000, 64'h1101, 64'h0020, 64'h0021};
        cmp_q("t1", got_q_a, exp);
        if (got_cyc_a.size() > 0 && acc_cyc_a.size() > 3)
            check("t1_latency", 64'(got_cyc_a[0] - acc_cyc_a[3]), 64'd3);
        else check("t1_latency_missing", 64'(got_cyc_a.size()), 64'd1);
        $display("t1 directed frame: %0d words", got_q_a.size());

        // ---- 2: downstream stalled; pipeline absorbs bank0, both banks then fill ----
        vp_a = 100; rp_a = 0;
        acc_cyc_a.delete(); got_q_a.delete();
        in_q_a = {beats, beats};
        repeat (25) @(negedge clk);
        #2;
        // bank0 drains into r/q, bank1 takes the tail, bank0 refills with frame 2 group 0
        check("t2_accepted", 64'(acc_cyc_a.size()), 64'd10);
        check("t2_tready_low", 64'(ip_a.tready), 64'd0);
        check("t2_tvalid", 64'(op_a.tvalid), 64'd1);
        check("t2_tdata_held", 64'(op_a.tdata), 64'h1000);
        rp_a = 100;
        for (int i = 0; i < 300 && got_q_a.size() < 8; i++) @(negedge clk);
        model(1, 2, 3, 1, 2, 2, in_q_a.size() == 0 ? {beats, beats} : beats, exp);
        cmp_q("t2", got_q_a, exp);
        $display("t2 stalled output: accepted=%0d words=%0d", acc_cyc_a.size(), got_q_a.size());

        // ---- 3: C, full rate, no tail ----
        vp_c = 100; rp_c = 100;
        acc_cyc_c.delete(); got_q_c.delete();
        gen(16, 8, beats);
        in_q_c = beats;
        for (int i = 0; i < 300 && got_q_c.size() < 8; i++) @(negedge clk);
        model(1, 2, 4, 2, 2, 1, beats, exp);
        cmp_q("t3", got_q_c, exp);
        foreach (got_q_c[i]) check("t3_lane1_live", 64'(got_q_c[i][15:8] != 0), 64'd1);
        if (acc_cyc_c.size() == 16) check("t3_no_bubble", 64'(acc_cyc_c[15] - acc_cyc_c[0]), 64'd15);
        else check("t3_accept_count", 64'(acc_cyc_c.size()), 64'd16);
        $display("t3 full rate: words=%0d", got_q_c.size());

        // ---- 4: B, random handshakes, 3 back-to-back frames ----
        vp_b = 50; rp_b = 50;
        acc_cyc_b.delete(); got_q_b.delete();
        gen(90, 16, beats);
        in_q_b = beats;
        for (int i = 0; i < 5000 && got_q_b.size() < 36; i++) @(negedge clk);
        model(2, 2, 5, 3, 3, 3, beats, exp);
        cmp_q("t4", got_q_b, exp);
        for (int i = 0; i < got_q_b.size(); i++) begin
            word = got_q_b[i];
            if (((i / 2) % 2) == 1) check("t4_tail_lane2", word[47:32], 64'd0);
        end
        $display("t4 random frames: words=%0d", got_q_b.size());

        // ---- 5: async reset mid-row on A ----
        vp_a = 100; rp_a = 0;
        acc_cyc_a.delete(); got_q_a.delete();
        in_q_a = '{64'h00, 64'h01, 64'h10, 64'h11, 64'h20};
        for (int i = 0; i < 100 && acc_cyc_a.size() < 5; i++) @(negedge clk);
        @(posedge clk);
        @(posedge clk);
        #3;
        check("t5_valid_before", 64'(op_a.tvalid), 64'd1);
        resetn = 0;
        #1;
        check("t5_rst_tvalid", 64'(op_a.tvalid), 64'd0);
        check("t5_rst_tdata", 64'(op_a.tdata), 64'd0);
        check("t5_rst_tready", 64'(ip_a.tready), 64'd0);
        in_q_a.delete(); got_q_a.delete(); acc_cyc_a.delete();
        repeat (2) @(posedge clk);
        #3;
        resetn = 1;
        rp_a = 100;
        gen(6, 8, beats);
        in_q_a = beats;
        for (int i = 0; i < 200 && got_q_a.size() < 4; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        model(1, 2, 3, 1, 2, 1, beats, exp);
        cmp_q("t5", got_q_a, exp);
        $display("t5 reset mid-row: words=%0d", got_q_a.size());

        // ---- 6: A streaming; each tail close coincides with the last read of the other bank ----
        vp_a = 100; rp_a = 100;
        acc_cyc_a.delete(); got_q_a.delete();
        gen(18, 8, beats);
        in_q_a = beats;
        for (int i = 0; i < 300 && got_q_a.size() < 12; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        model(1, 2, 3, 1, 2, 3, beats, exp);
        cmp_q("t6", got_q_a, exp);
        if (acc_cyc_a.size() == 18) check("t6_no_bubble", 64'(acc_cyc_a[17] - acc_cyc_a[0]), 64'd17);
        else check("t6_accept_count", 64'(acc_cyc_a.size()), 64'd18);
        $display("t6 coincident close/free: words=%0d", got_q_a.size());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
